// File: rtl/cw_pkg.sv
// Shared types and timing constants for the CW beacon keyer: Morse symbol
// codes, sequencer states and the unit counts each symbol occupies.
package cw_pkg;

    typedef enum logic [1:0] {
        SYM_DOT  = 2'b00,
        SYM_DASH = 2'b01,
        SYM_LGAP = 2'b10,
        SYM_WGAP = 2'b11
    } sym_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_MARK,
        ST_SPACE,
        ST_NEXT,
        ST_END,
        ST_PAUSE
    } state_e;

    localparam logic [2:0] DOT_UNITS      = 3'd1;
    localparam logic [2:0] DASH_UNITS     = 3'd3;
    localparam logic [2:0] ELEM_GAP_UNITS = 3'd1;
    localparam logic [2:0] LGAP_UNITS     = 3'd2;
    localparam logic [2:0] WGAP_UNITS     = 3'd6;

    // Units of the first timed phase of a symbol: mark length for dot/dash,
    // silence length for the gap symbols.
    function automatic logic [2:0] sym_units(input sym_e sym);
        case (sym)
            SYM_DOT:  return DOT_UNITS;
            SYM_DASH: return DASH_UNITS;
            SYM_LGAP: return LGAP_UNITS;
            default:  return WGAP_UNITS;
        endcase
    endfunction

    function automatic logic sym_is_mark(input sym_e sym);
        return (sym == SYM_DOT) || (sym == SYM_DASH);
    endfunction

endpackage

// File: rtl/cw_clk_div.sv
// Free-running toggle divider: the output flips every HALF clock cycles.
// o_out_nxt exposes the value o_out takes after the coming edge.
module cw_clk_div #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_out,
    output logic o_out_nxt
);

    localparam int               CNT_W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             w_wrap;

    assign w_wrap    = (r_cnt == CNT_LAST);
    assign o_out_nxt = w_wrap ? ~r_out : r_out;
    assign o_out     = r_out;

    // NOTE: state registers use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            r_out <= o_out_nxt;
        end
    end

endmodule

// File: rtl/cw_beacon_keyer.sv
// Morse beacon message sequencer: steps through MESSAGE symbol by symbol in
// dot-length units, with start/busy/done handshake, auto-repeat and abort.
module cw_beacon_keyer
    import cw_pkg::*;
#(
    parameter int                   DOT_CLKS     = 4096,
    parameter int                   TONE_HALF    = 8192,
    parameter int                   RF_HALF      = 16,
    parameter int                   MSG_LEN      = 4,
    parameter logic [2*MSG_LEN-1:0] MESSAGE      = 8'hE4,
    parameter int                   REPEAT_UNITS = 14,
    parameter int                   MCW          = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic start,
    input  logic repeat_en,
    output logic busy,
    output logic done,
    output logic key_out,
    output logic tone_out,
    output logic rf_out,
    output logic [((MSG_LEN > 1) ? $clog2(MSG_LEN) : 1)-1:0] sym_idx
);

    localparam int IDX_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int UNIT_W    = $clog2(DOT_CLKS);
    localparam int UNITS_MAX = (REPEAT_UNITS > 6) ? REPEAT_UNITS : 6;
    localparam int UNITS_W   = $clog2(UNITS_MAX + 1);

    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(DOT_CLKS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(MSG_LEN - 1);

    state_e             r_state, w_state_nxt;
    logic [UNIT_W-1:0]  r_unit,  w_unit_nxt;
    logic [UNITS_W-1:0] r_units, w_units_nxt;
    logic [IDX_W-1:0]   r_idx,   w_idx_nxt;
    logic               w_done_nxt;
    logic               r_busy, r_done, r_key, r_rf;
    logic               w_tone, w_tone_nxt, w_rf_ph, w_rf_ph_nxt;
    logic               w_key_nxt, w_unit_end;
    sym_e               w_sym;

    cw_clk_div #(.HALF(TONE_HALF)) u_tone_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .o_out     (w_tone),
        .o_out_nxt (w_tone_nxt)
    );

    cw_clk_div #(.HALF(RF_HALF)) u_rf_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .o_out     (w_rf_ph),
        .o_out_nxt (w_rf_ph_nxt)
    );

    assign w_sym      = sym_e'(MESSAGE[2*r_idx +: 2]);
    assign w_unit_end = (r_unit == UNIT_LAST);

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_unit_nxt  = r_unit;
        w_units_nxt = r_units;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;

        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_unit_nxt  = '0;
            w_units_nxt = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_FETCH;
                        w_idx_nxt   = '0;
                    end
                end
                ST_FETCH: begin
                    w_unit_nxt  = '0;
                    w_units_nxt = UNITS_W'(sym_units(w_sym) - 3'd1);
                    w_state_nxt = sym_is_mark(w_sym) ? ST_MARK : ST_SPACE;
                end
                ST_MARK, ST_SPACE, ST_PAUSE: begin
                    // r_units holds the units still to run after the current one.
                    if (!w_unit_end) begin
                        w_unit_nxt = r_unit + 1'b1;
                    end else begin
                        w_unit_nxt = '0;
                        if (r_units != '0) begin
                            w_units_nxt = r_units - 1'b1;
                        end else if (r_state == ST_MARK) begin
                            w_state_nxt = ST_SPACE;
                            w_units_nxt = UNITS_W'(ELEM_GAP_UNITS - 3'd1);
                        end else if (r_state == ST_SPACE) begin
                            w_state_nxt = ST_NEXT;
                        end else begin
                            w_state_nxt = ST_FETCH;
                            w_idx_nxt   = '0;
                        end
                    end
                end
                ST_NEXT: begin
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = ST_END;
                    end else begin
                        w_state_nxt = ST_FETCH;
                        w_idx_nxt   = r_idx + 1'b1;
                    end
                end
                ST_END: begin
                    if (!repeat_en) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else if (REPEAT_UNITS == 0) begin
                        w_state_nxt = ST_FETCH;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_PAUSE;
                        w_unit_nxt  = '0;
                        w_units_nxt = UNITS_W'(REPEAT_UNITS - 1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Key and carrier are registered from the same next state so they align.
    assign w_key_nxt = (w_state_nxt == ST_MARK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_unit  <= '0;
            r_units <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_key   <= 1'b0;
            r_rf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_unit  <= w_unit_nxt;
            r_units <= w_units_nxt;
            r_idx   <= w_idx_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_done_nxt;
            r_key   <= w_key_nxt;
            r_rf    <= w_key_nxt & w_rf_ph_nxt & ((MCW != 0) ? w_tone_nxt : 1'b1);
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign key_out  = r_key;
    assign tone_out = w_tone;
    assign rf_out   = r_rf;
    assign sym_idx  = r_idx;

endmodule

// File: tb/tb_cw_beacon_keyer.sv
// Self-checking bench for cw_beacon_keyer: a timeline model of the message
// (frames per cycle) predicts every output of an MCW and a pure-CW instance.
module tb_cw_beacon_keyer;

    localparam int         DOT = 4;
    localparam int         TH  = 8;
    localparam int         RH  = 2;
    localparam int         ML  = 4;
    localparam int         RU  = 14;
    localparam logic [7:0] MSG = 8'hE4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       start = 1'b0;
    logic       repeat_en = 1'b0;

    logic       busy, done, key_out, tone_out, rf_out;
    logic [1:0] sym_idx;
    logic       busy_c, done_c, key_c, tone_c, rf_c;
    logic [1:0] idx_c;

    cw_beacon_keyer #(
        .DOT_CLKS(DOT), .TONE_HALF(TH), .RF_HALF(RH), .MSG_LEN(ML),
        .MESSAGE(MSG), .REPEAT_UNITS(RU), .MCW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
        .repeat_en(repeat_en), .busy(busy), .done(done), .key_out(key_out),
        .tone_out(tone_out), .rf_out(rf_out), .sym_idx(sym_idx)
    );

    cw_beacon_keyer #(
        .DOT_CLKS(DOT), .TONE_HALF(TH), .RF_HALF(RH), .MSG_LEN(ML),
        .MESSAGE(MSG), .REPEAT_UNITS(RU), .MCW(0)
    ) dut_cw (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
        .repeat_en(repeat_en), .busy(busy_c), .done(done_c), .key_out(key_c),
        .tone_out(tone_c), .rf_out(rf_c), .sym_idx(idx_c)
    );

    always #5 clk = ~clk;

    // One frame = expected outputs after one clock edge.
    typedef struct packed {
        logic       key;
        logic       busy;
        logic       done;
        logic       is_end;
        logic [1:0] idx;
    } frame_t;

    frame_t q[$];
    frame_t cur;
    int     cyc;
    int     passes, total, fails;
    int     bcnt, dcnt, kcnt;

    function automatic frame_t mk(input logic k, input logic b, input logic d,
                                  input logic e, input logic [1:0] i);
        frame_t f;
        f.key    = k;
        f.busy   = b;
        f.done   = d;
        f.is_end = e;
        f.idx    = i;
        return f;
    endfunction

    // Whole-message timeline: per symbol a fetch cycle, the mark and silence
    // lengths in units, and a step cycle; then one end cycle.
    task automatic push_msg();
        int         mark_u[4];
        int         space_u[4];
        logic [7:0] m;
        mark_u  = '{1, 3, 0, 0};
        space_u = '{1, 1, 2, 6};
        m = MSG;
        for (int i = 0; i < ML; i++) begin
            int s;
            s = int'(m[2*i +: 2]);
            q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'(i)));
            repeat (mark_u[s] * DOT) q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 2'(i)));
            repeat (space_u[s] * DOT) q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'(i)));
            q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'(i)));
        end
        q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 2'(ML - 1)));
    endtask

    task automatic model_edge(input logic en, input logic st, input logic rp);
        cyc++;
        if (!en) begin
            q.delete();
            cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (cur.is_end) begin
            if (rp) begin
                repeat (RU * DOT) q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'(ML - 1)));
                push_msg();
                cur = q.pop_front();
            end else begin
                cur = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
            end
        end else if (!cur.busy && st) begin
            push_msg();
            cur = q.pop_front();
        end else begin
            cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, {busy, busy_c}, 0);
        check({tag, "_done"}, {done, done_c}, 0);
        check({tag, "_key"},  {key_out, key_c}, 0);
        check({tag, "_tone"}, {tone_out, tone_c}, 0);
        check({tag, "_rf"},   {rf_out, rf_c}, 0);
        check({tag, "_idx"},  {sym_idx, idx_c}, 0);
    endtask

    // Drive inputs after a falling edge, step the model on the rising edge,
    // compare on the next falling edge.
    task automatic cycle(input logic en, input logic st, input logic rp);
        logic tone_e, rf_e;
        enable    = en;
        start     = st;
        repeat_en = rp;
        @(posedge clk);
        model_edge(en, st, rp);
        @(negedge clk);
        tone_e = ((cyc / TH) % 2) == 1;
        rf_e   = ((cyc / RH) % 2) == 1;
        check("key",    key_out,  cur.key);
        check("busy",   busy,     cur.busy);
        check("done",   done,     cur.done);
        check("idx",    sym_idx,  cur.idx);
        check("tone",   tone_out, tone_e);
        check("rf_mcw", rf_out,   cur.key & rf_e & tone_e);
        check("key_cw", key_c,    cur.key);
        check("done_cw", done_c,  cur.done);
        check("rf_cw",  rf_c,     cur.key & rf_e);
        bcnt += int'(busy);
        dcnt += int'(done);
        kcnt += int'(key_out);
    endtask

    task automatic model_reset();
        q.delete();
        cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        cyc = 0;
    endtask

    initial begin
        passes = 0;
        total  = 0;
        fails  = 0;
        bcnt   = 0;
        dcnt   = 0;
        kcnt   = 0;
        model_reset();

        repeat (2) @(negedge clk);
        check_zero("por");
        rst_n = 1'b1;

        // Idle, then a start with enable low must be ignored.
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("start_no_enable", busy, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0);

        // Full message, no repeat, stray starts while busy.
        bcnt = 0; dcnt = 0; kcnt = 0;
        cycle(1'b1, 1'b1, 1'b0);
        for (int c = 1; c < 80; c++) cycle(1'b1, (c == 30) || (c == 50), 1'b0);
        check("busy_cycles", bcnt, 65);
        check("done_pulses", dcnt, 1);
        check("key_cycles",  kcnt, 16);

        // Abort in the middle of the dash, then restart from symbol 0.
        dcnt = 0;
        cycle(1'b1, 1'b1, 1'b0);
        repeat (15) cycle(1'b1, 1'b0, 1'b0);
        check("in_dash_key", key_out, 1'b1);
        check("in_dash_idx", sym_idx, 2'd1);
        cycle(1'b0, 1'b0, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
        check("abort_no_done", dcnt, 0);
        cycle(1'b1, 1'b1, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        check("restart_idx", sym_idx, 2'd0);
        repeat (70) cycle(1'b1, 1'b0, 1'b0);

        // Repeat: repeat_en drops during the pause, the second pass still runs.
        bcnt = 0; dcnt = 0;
        cycle(1'b1, 1'b1, 1'b1);
        for (int c = 1; c < 130; c++) cycle(1'b1, 1'b0, c < 68);
        check("repeat_busy", bcnt, 130);
        check("repeat_no_done", dcnt, 0);
        repeat (120) cycle(1'b1, 1'b0, 1'b0);
        check("repeat_final_done", dcnt, 1);

        // Asynchronous reset in the middle of a message.
        cycle(1'b1, 1'b1, 1'b0);
        repeat (10) cycle(1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        repeat (3) begin
            @(negedge clk);
            check_zero("rst_hold");
        end
        rst_n = 1'b0;
        model_reset();
        rst_n = 1'b1;
        bcnt = 0;
        repeat (20) cycle(1'b1, 1'b0, 1'b0);
        check("post_rst_idle", bcnt, 0);

        // Randomised transactions.
        for (int t = 0; t < 8; t++) begin
            logic rep;
            int   abort_at;
            repeat ($urandom_range(0, 6)) cycle(1'($urandom_range(0, 4) != 0), 1'b0, 1'b0);
            rep      = ($urandom_range(0, 2) == 0);
            abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : 1000;
            cycle(1'b1, 1'b1, rep);
            for (int c = 1; c < 400 && (q.size() > 0 || cur.busy); c++) begin
                if (c == abort_at) cycle(1'b0, 1'b0, 1'b0);
                else cycle(1'b1, $urandom_range(0, 7) == 0,
                           rep ? 1'($urandom_range(0, 3) != 0) : 1'b0);
            end
            if (cur.busy) cycle(1'b0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/cw_beacon_keyer.md
# cw_beacon_keyer

Parametrised Morse (CW/MCW) beacon keyer for the CPLD transmitter. It generalises the fixed free-running beacon into a message sequencer. A symbol-encoded message parameter drives a unit-timed FSM with start/busy/done control, optional auto-repeat and enable-abort. It also has independent tone and RF dividers. It sits between board-level control pins and the RF/LF output pins.

## Interface
Parameters:
- DOT_CLKS, 4096: clock cycles per Morse unit (dot length); legal range ≥ 2.
- TONE_HALF, 8192: cycles per half period of the audio tone.
- RF_HALF, 16: cycles per half period of the RF carrier.
- MSG_LEN, 4: number of 2-bit symbols in MESSAGE; legal range ≥ 1.
- MESSAGE, 8'hE4: packed symbols, symbol 0 in bits [1:0].
- REPEAT_UNITS, 14: units of silence between message repeats.
- MCW, 1: 1 gates RF with the tone (MCW mode); 0 gives pure CW.

Ports:
- clk: input, 1 bit. Single clock; all state on its rising edge.
- rst_n: input, 1 bit. Asynchronous, active-low reset.
- enable: input, 1 bit. Level; low aborts and holds the keyer idle.
- start: input, 1 bit. Single-cycle request to send the message.
- repeat_en: input, 1 bit. Level; sampled at end of message.
- busy: output, 1 bit. High from acceptance until return to IDLE.
- done: output, 1 bit. One-cycle pulse when a non-repeated message finishes.
- key_out: output, 1 bit. Keying envelope (LF output).
- tone_out: output, 1 bit. Free-running audio square wave.
- rf_out: output, 1 bit. Keyed carrier: key & rf, additionally & tone when MCW=1.
- sym_idx: output, $clog2(MSG_LEN) bits (minimum 1). Index of the current symbol.

## Operation
Symbol codes:
- 00 dot: key 1 unit, then 1 unit off.
- 01 dash: key 3 units, then 1 unit off.
- 10 letter gap: 2 units off (total 3 with the preceding element gap).
- 11 word gap: 6 units off.

FSM states:
- IDLE → FETCH: on start & enable & !busy.
- FETCH: decodes MESSAGE[2*sym_idx +: 2] and loads the unit count.
- MARK: key_out=1.
- SPACE: key_out=0.
- NEXT: increments sym_idx. At MSG_LEN-1 it goes to END instead.
- END: if repeat_en=1 → PAUSE. Otherwise it pulses done and goes to IDLE.
- PAUSE: REPEAT_UNITS units of silence, then sym_idx=0 and → FETCH.

Gap symbols go FETCH → SPACE directly.

Boundary conditions:
- start while busy: ignored.
- start with enable low: ignored.
- enable deasserted in any non-IDLE state: next edge gives IDLE, key_out=0, busy=0, sym_idx=0, no done.
- repeat_en is sampled only in END. Dropping it during PAUSE does not stop the repeat.
- Leading or consecutive gap symbols are legal and are simply timed.
- The unit counter counts 0..DOT_CLKS-1. The units counter counts down to 0; there is no off-by-one on the last unit.

Tone and carrier:
- tone and carrier are free-running from reset and not synchronised to keying.
- rf_out is registered: key_out & rf_ph & (MCW ? tone_out : 1).

## Timing
Reset values:
- busy=0, done=0, key_out=0, tone_out=0, rf_out=0, sym_idx=0, state IDLE.
- All divider counters are 0.

Latency:
- Accepted start at edge N: busy=1 and FETCH at N+1.
- key_out=1 at N+2 for a leading dot.
- FETCH and NEXT each cost one cycle, outside unit timing.
- A dot mark is exactly DOT_CLKS cycles of key_out=1.
- done is high for exactly one cycle, coincident with busy falling.
- tone_out toggles every TONE_HALF cycles; rf phase toggles every RF_HALF cycles.
- rf_out lags key_out by 0 cycles: both are registered from the same state.

## Structure
Package cw_pkg holds:
- symbol enum (SYM_DOT, SYM_DASH, SYM_LGAP, SYM_WGAP).
- state enum.
- unit-count constants: 1, 3, 1, 2, 6.

Sub-module cw_clk_div (parameter HALF): a free-running toggle divider with rst_n, instantiated twice (tone and RF).

## Test plan
- Reset held mid-message:
  - All outputs 0 asynchronously.
  - After release, no activity until start.
- DOT_CLKS=4, MESSAGE=8'hE4, start pulse, repeat_en=0:
  - key_out high 4 cycles, low 4, high 12, then low.
  - done pulses once.
  - Total busy = 4+4+12+4+8+24 units' worth of cycles plus 1 cycle per FETCH/NEXT/END.
- Same message with repeat_en=1:
  - After word gap, 14×4=56 cycles silence, then dot restarts at sym_idx=0.
  - No done pulse.
- enable dropped in the middle of the dash:
  - key_out=0 and busy=0 on the next edge.
  - done stays 0.
  - A later start sends from symbol 0.
- start pulsed again while busy:
  - No effect on timing or sym_idx.
- MCW=1, TONE_HALF=8, RF_HALF=2, during a mark:
  - rf_out toggles every 2 cycles only while tone_out=1.
- MCW=0, same settings:
  - rf_out toggles continuously during the mark.
